// File: rtl/quad_encoder_mmio_if.sv
// Peripheral bus bundle for quad_encoder_mmio.
//
// Handshake: there is no valid/ready pair on this bus. A write is a single
// strobe: bus_we=1 is captured on every rising clk edge on which it is seen.
// A read is combinational. bus_rdata reflects the addressed register while
// bus_re=1, and it is 0 otherwise. The slave never stalls.
//
// Signals:
//   bus_addr  [31:0]  byte address, fully decoded
//   bus_we            write strobe
//   bus_re            read strobe
//   bus_wdata [31:0]  write data
//   bus_rdata [31:0]  read data (slave -> master, combinational)
interface quad_encoder_mmio_if;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (
    output bus_addr,
    output bus_we,
    output bus_re,
    output bus_wdata,
    input  bus_rdata
  );

  modport slave (
    input  bus_addr,
    input  bus_we,
    input  bus_re,
    input  bus_wdata,
    output bus_rdata
  );
endinterface

// File: rtl/quad_encoder_mmio.sv
// quad_encoder_mmio: memory-mapped x4 quadrature decoder with a signed
// 32-bit position counter and a direction flag.
//
// Register map (byte offsets, full 32-bit compare):
//   0x00 CTRL     RW  bit0 ENABLE, bit1 CLR_POS (write-1 pulse, reads 0)
//   0x04 STATUS   RO  bit0 DIR, bit1 ENABLE, bit2 ERR (0 unless ENC_ERR_DETECT_EN)
//   0x08 POSITION RO  two's-complement count, wraps modulo 2^32
//
// Optional feature macro: ENC_ERR_DETECT_EN adds a sticky illegal-transition
// flag (STATUS bit2). It is cleared by a CTRL write with CLR_POS=1.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    quad_encoder_mmio_if.slave register bus
//   enc_a  encoder channel A (asynchronous)
//   enc_b  encoder channel B (asynchronous)
module quad_encoder_mmio (
  input  logic                 clk,
  input  logic                 reset,
  quad_encoder_mmio_if.slave   bus,
  input  logic                 enc_a,
  input  logic                 enc_b
);

  localparam logic [31:0] ADDR_CTRL     = 32'h0000_0000;
  localparam logic [31:0] ADDR_STATUS   = 32'h0000_0004;
  localparam logic [31:0] ADDR_POSITION = 32'h0000_0008;

  logic [1:0]  sync_s1;
  logic [1:0]  sync_s2;
  logic        enable;
  logic        dir;
  logic [31:0] position;
  logic        err;

  logic        ctrl_wr;
  logic        clr_pos;
  logic [1:0]  step_delta;
  logic        step_fwd;
  logic        step_bwd;
  logic        step_bad;

  // Maps the {A,B} pair to its position along the forward Gray sequence
  // 00 -> 01 -> 11 -> 10. A forward step then advances the index by 1 mod 4.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    logic [1:0] idx;
    case (ab)
      2'b00:   idx = 2'd0;
      2'b01:   idx = 2'd1;
      2'b11:   idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // Two-flop synchronizer. It keeps running while disabled so that enabling
  // the decoder starts from the current pin state, with no stale step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_s1 <= 2'b00;
      sync_s2 <= 2'b00;
    end else begin
      sync_s1 <= {enc_a, enc_b};
      sync_s2 <= sync_s1;
    end
  end

  // The previous state is s2 and the current state is s1.
  // delta 1 = forward, 3 = backward, 2 = both bits flipped (illegal).
  assign step_delta = gray_idx(sync_s1) - gray_idx(sync_s2);
  assign step_fwd   = (step_delta == 2'd1);
  assign step_bwd   = (step_delta == 2'd3);
  assign step_bad   = (step_delta == 2'd2);

  assign ctrl_wr = bus.bus_we && (bus.bus_addr == ADDR_CTRL);
  assign clr_pos = ctrl_wr && bus.bus_wdata[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable   <= 1'b0;
      dir      <= 1'b0;
      position <= 32'h0;
    end else begin
      if (ctrl_wr) begin
        enable <= bus.bus_wdata[0];
      end
      // Clearing wins over a step decoded on the same edge.
      if (clr_pos) begin
        position <= 32'h0;
      end else if (enable && step_fwd) begin
        position <= position + 32'd1;
      end else if (enable && step_bwd) begin
        position <= position - 32'd1;
      end
      if (enable && step_fwd) begin
        dir <= 1'b1;
      end else if (enable && step_bwd) begin
        dir <= 1'b0;
      end
    end
  end

`ifdef ENC_ERR_DETECT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (clr_pos) begin
      err <= 1'b0;
    end else if (enable && step_bad) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_step_bad;
  assign unused_step_bad = step_bad;
  assign err = 1'b0;
`endif

  always_comb begin
    bus.bus_rdata = 32'h0;
    if (bus.bus_re) begin
      case (bus.bus_addr)
        ADDR_CTRL:     bus.bus_rdata = {31'h0, enable};
        ADDR_STATUS:   bus.bus_rdata = {29'h0, err, enable, dir};
        ADDR_POSITION: bus.bus_rdata = position;
        default:       bus.bus_rdata = 32'h0;
      endcase
    end
  end

  // Only ENABLE and CLR_POS are stored or acted on.
  logic unused_wdata;
  assign unused_wdata = ^bus.bus_wdata[31:2];

endmodule

// File: tb/tb_quad_encoder_mmio.sv
module tb_quad_encoder_mmio;

  localparam logic [31:0] A_CTRL   = 32'h0;
  localparam logic [31:0] A_STATUS = 32'h4;
  localparam logic [31:0] A_POS    = 32'h8;
  localparam logic [31:0] A_NONE   = 32'hC;

`ifdef ENC_ERR_DETECT_EN
  localparam bit ERR_FEATURE = 1'b1;
`else
  localparam bit ERR_FEATURE = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic enc_a = 1'b0;
  logic enc_b = 1'b0;

  always #5 clk = ~clk;

  quad_encoder_mmio_if bus_if ();

  quad_encoder_mmio dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .enc_a (enc_a),
    .enc_b (enc_b)
  );

  // ---------------- scoreboard state ----------------
  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] exp_q[$];

  // Reference model of the register state.
  logic [1:0]  pins_m = 2'b00;
  logic [31:0] pos_m  = 32'h0;
  logic        dir_m  = 1'b0;
  logic        en_m   = 1'b0;
  logic        err_m  = 1'b0;

  function automatic logic [1:0] fwd_next(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] status_m();
    return {29'h0, err_m, en_m, dir_m};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus_if.bus_addr  = addr;
    bus_if.bus_wdata = data;
    bus_if.bus_we    = 1'b1;
    @(negedge clk);
    bus_if.bus_we    = 1'b0;
    if (addr == A_CTRL) begin
      en_m = data[0];
      if (data[1]) begin
        pos_m = 32'h0;
        err_m = 1'b0;
      end
    end
  endtask

  // Pushes the expected word, performs a read and pops/compares it.
  task automatic read_expect(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    exp_q.push_back(exp);
    bus_if.bus_addr = addr;
    bus_if.bus_re   = 1'b1;
    #1;
    check(tag, bus_if.bus_rdata, exp_q.pop_front());
    bus_if.bus_re   = 1'b0;
  endtask

  // Drives one new pin state and steps the model the way an x4 decoder should.
  task automatic drive_pins(input logic [1:0] ab);
    @(negedge clk);
    {enc_a, enc_b} = ab;
    if (en_m) begin
      if (ab == fwd_next(pins_m)) begin
        pos_m = pos_m + 32'd1;
        dir_m = 1'b1;
      end else if (fwd_next(ab) == pins_m) begin
        pos_m = pos_m - 32'd1;
        dir_m = 1'b0;
      end else if (ab != pins_m) begin
        err_m = err_m | ERR_FEATURE;
      end
    end
    pins_m = ab;
  endtask

  task automatic fwd_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive_pins(2'b01);
      drive_pins(2'b11);
      drive_pins(2'b10);
      drive_pins(2'b00);
    end
  endtask

  task automatic bwd_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive_pins(2'b10);
      drive_pins(2'b11);
      drive_pins(2'b01);
      drive_pins(2'b00);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus_if.bus_addr  = 32'h0;
    bus_if.bus_we    = 1'b0;
    bus_if.bus_re    = 1'b0;
    bus_if.bus_wdata = 32'h0;
    idle(3);
    reset = 1'b1;
    idle(2);

    read_expect("rst_status", A_STATUS, 32'h0);
    read_expect("rst_pos",    A_POS,    32'h0);
    read_expect("rst_ctrl",   A_CTRL,   32'h0);
    read_expect("unmapped",   A_NONE,   32'h0);

    // Forward counting: 5 cycles x 4 edges = 20.
    bus_write(A_CTRL, 32'h1);
    fwd_cycles(5);
    idle(2);
    read_expect("pos_fwd",    A_POS,    32'h0000_0014);
    read_expect("status_fwd", A_STATUS, 32'h0000_0003);
    check("model_fwd", pos_m, 32'h0000_0014);

    // Read strobe low must give 0 even on a mapped, non-zero register.
    @(negedge clk);
    bus_if.bus_addr = A_STATUS;
    bus_if.bus_re   = 1'b0;
    #1;
    check("re_low", bus_if.bus_rdata, 32'h0);

    // Latency: a step is not visible one edge after sampling, but is after two.
    drive_pins(2'b10);
    read_expect("lat_before", A_POS, 32'h0000_0014);
    read_expect("lat_after",  A_POS, 32'h0000_0013);
    drive_pins(2'b11);
    drive_pins(2'b01);
    drive_pins(2'b00);
    // 20 backward cycles in total: 20 - 80 = -60.
    bwd_cycles(19);
    idle(2);
    read_expect("pos_bwd",    A_POS,    32'hFFFF_FFC4);
    read_expect("status_bwd", A_STATUS, 32'h0000_0002);

    // CLR_POS pulse, ENABLE kept.
    bus_write(A_CTRL, 32'h3);
    read_expect("pos_clr",  A_POS,  32'h0);
    read_expect("ctrl_clr", A_CTRL, 32'h0000_0001);

    // Writes to read-only and unmapped addresses are ignored.
    bus_write(A_POS,    32'h0000_1234);
    bus_write(A_STATUS, 32'h0000_00FF);
    bus_write(A_NONE,   32'hFFFF_FFFF);
    read_expect("pos_ro",    A_POS,    32'h0);
    read_expect("status_ro", A_STATUS, status_m());
    read_expect("ctrl_ro",   A_CTRL,   32'h0000_0001);

    // Wrap below zero and back.
    drive_pins(2'b10);
    idle(2);
    read_expect("wrap_dn", A_POS, 32'hFFFF_FFFF);
    drive_pins(2'b00);
    idle(2);
    read_expect("wrap_up", A_POS, 32'h0);
    read_expect("wrap_status", A_STATUS, 32'h0000_0003);

    // Upper CTRL bits are not stored.
    bus_write(A_CTRL, 32'hFFFF_FFFD);
    read_expect("ctrl_upper", A_CTRL, 32'h0000_0001);

    // Disabled: pins move, count and DIR are frozen.
    drive_pins(2'b10);
    idle(2);
    bus_write(A_CTRL, 32'h0);
    fwd_cycles(20);
    drive_pins(2'b00);
    idle(2);
    read_expect("pos_dis",    A_POS,    pos_m);
    read_expect("pos_dis_k",  A_POS,    32'hFFFF_FFFF);
    read_expect("status_dis", A_STATUS, 32'h0000_0000);

    // Re-enable with pins at 00: no step.
    bus_write(A_CTRL, 32'h1);
    idle(3);
    read_expect("pos_reen", A_POS, 32'hFFFF_FFFF);

    // Illegal jump 00 -> 11 and back.
    drive_pins(2'b11);
    idle(2);
    read_expect("pos_illegal", A_POS, 32'hFFFF_FFFF);
    read_expect("status_err",  A_STATUS, ERR_FEATURE ? 32'h0000_0006 : 32'h0000_0002);
    drive_pins(2'b00);
    idle(2);
    read_expect("pos_illegal2", A_POS, pos_m);
    bus_write(A_CTRL, 32'h3);
    read_expect("status_errclr", A_STATUS, 32'h0000_0002);
    read_expect("pos_errclr",    A_POS,    32'h0);

    // Asynchronous reset in the middle of activity.
    drive_pins(2'b01);
    idle(2);
    read_expect("pos_prerst", A_POS, 32'h0000_0001);
    @(negedge clk);
    #2;
    reset = 1'b0;
    pos_m = 32'h0;
    dir_m = 1'b0;
    en_m  = 1'b0;
    err_m = 1'b0;
    read_expect("inrst_pos",    A_POS,    32'h0);
    read_expect("inrst_ctrl",   A_CTRL,   32'h0);
    read_expect("inrst_status", A_STATUS, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    idle(3);
    read_expect("postrst_pos", A_POS, 32'h0);
    bus_write(A_CTRL, 32'h1);
    drive_pins(2'b11);
    idle(2);
    read_expect("postrst_step",   A_POS,    32'h0000_0001);
    read_expect("postrst_status", A_STATUS, status_m());

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
